// File: rtl/peek_display_ctrl.sv
// rtl/peek_display_ctrl.sv - debounced step/peek harness with run mode, cycle counter and paged hex display
// Optional macro PEEK_BREAKPOINT_EN adds BpArm/BpValue and a run-mode PC breakpoint.
module peek_display_ctrl #(
  parameter int NUM_TAPS   = 16,
  parameter int TAP_W      = 32,
  parameter int NUM_DIGITS = 4,
  parameter int CYC_W      = 8,
  parameter int DEB_CYC    = 250000,
  parameter int RUN_DIV    = 5000000,
  parameter int SCROLL_DIV = 50000000,
  localparam int SEL_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int WIN_BITS  = 4 * NUM_DIGITS,
  localparam int WINDOWS   = (TAP_W + WIN_BITS - 1) / WIN_BITS,
  localparam int WIN_W     = (WINDOWS > 1) ? $clog2(WINDOWS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        StepKey,
  input  logic                        PeekKey,
  input  logic [SEL_W-1:0]            Sel,
  input  logic                        RunMode,
  input  logic                        CycleClear,
  input  logic                        ScrollEn,
  input  logic [WIN_W-1:0]            WindowSel,
  input  logic [NUM_TAPS*TAP_W-1:0]   TapBus,
`ifdef PEEK_BREAKPOINT_EN
  input  logic                        BpArm,
  input  logic [TAP_W-1:0]            BpValue,
`endif
  output logic                        StepPulse,
  output logic [CYC_W-1:0]            CycleCount,
  output logic [WIN_W-1:0]            WinIdx,
  output logic                        Halted,
  output logic [NUM_DIGITS*7-1:0]     HexValue,
  output logic [(CYC_W/4)*7-1:0]      HexCycle
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int RUN_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);
  localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOWS - 1);

  logic [1:0]             w_keys;
  logic [1:0]             r_sync1, r_sync2, r_db;
  logic [DEB_W-1:0]       r_deb_cnt [2];
  logic                   r_step_db_d;
  logic                   r_step_pulse, r_pulse_d;
  logic [RUN_W-1:0]       r_run_cnt;
  logic [CYC_W-1:0]       r_cycles;
  logic [TAP_W-1:0]       r_disp;
  logic [TAP_W-1:0]       w_tap [2**SEL_W];
  logic                   w_halted, w_run_active, w_run_wrap, w_key_step;
  logic                   r_scroll_en_d;
  logic [SEL_W-1:0]       r_sel_d;
  logic [SCR_W-1:0]       r_scroll_cnt;
  logic [WIN_W-1:0]       r_win, w_win_clamp;
  logic [WINDOWS*WIN_BITS-1:0] w_pad;
  logic [WIN_BITS-1:0]    w_win_val;

  // bit 0 = step key, bit 1 = peek key; both active-low, released = 1
  assign w_keys = {PeekKey, StepKey};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_db        <= '1;
      r_step_db_d <= 1'b1;
      for (int k = 0; k < 2; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_sync1     <= w_keys;
      r_sync2     <= r_sync1;
      r_step_db_d <= r_db[0];
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_deb_cnt[k] == DEB_LAST) begin
            r_db[k]      <= r_sync2[k];
            r_deb_cnt[k] <= '0;
          end else begin
            r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
          end
        end else begin
          r_deb_cnt[k] <= '0;
        end
      end
    end
  end

  assign w_key_step   = r_step_db_d & ~r_db[0];
  assign w_run_active = RunMode & ~w_halted;
  assign w_run_wrap   = w_run_active && (r_run_cnt == RUN_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_cnt    <= '0;
      r_step_pulse <= 1'b0;
      r_pulse_d    <= 1'b0;
      r_cycles     <= '0;
    end else begin
      if (!RunMode)          r_run_cnt <= '0;
      else if (w_run_wrap)   r_run_cnt <= '0;
      else if (w_run_active) r_run_cnt <= r_run_cnt + 1'b1;
      r_step_pulse <= w_run_active ? w_run_wrap : w_key_step;
      r_pulse_d    <= r_step_pulse;
      if (CycleClear)        r_cycles <= '0;
      else if (r_step_pulse) r_cycles <= r_cycles + 1'b1;
    end
  end

  // Unused select codes read as zero.
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_tap
    if (i < NUM_TAPS) begin : g_real
      assign w_tap[i] = TapBus[i*TAP_W +: TAP_W];
    end else begin : g_zero
      assign w_tap[i] = '0;
    end
  end

  // In run mode the CPU state only settles after a step, so sample it the cycle after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_disp <= '0;
    else if (!r_db[1])              r_disp <= w_tap[0];
    else if (!RunMode || r_pulse_d) r_disp <= w_tap[Sel];
  end

`ifdef PEEK_BREAKPOINT_EN
  logic r_halted, r_bp_chk;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_halted <= 1'b0;
      r_bp_chk <= 1'b0;
    end else begin
      r_bp_chk <= r_step_pulse & w_run_active;
      if (!BpArm || !RunMode)                    r_halted <= 1'b0;
      else if (r_bp_chk && w_tap[0] == BpValue)  r_halted <= 1'b1;
    end
  end
  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  always_comb begin
    w_win_clamp = WIN_LAST;
    for (int w = 0; w < WINDOWS; w++)
      if (WindowSel == WIN_W'(w)) w_win_clamp = WindowSel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scroll_en_d <= 1'b0;
      r_sel_d       <= '0;
      r_scroll_cnt  <= '0;
      r_win         <= '0;
    end else begin
      r_scroll_en_d <= ScrollEn;
      r_sel_d       <= Sel;
      if (!ScrollEn) begin
        r_scroll_cnt <= '0;
        r_win        <= w_win_clamp;
      end else if (!r_scroll_en_d || Sel != r_sel_d) begin
        r_scroll_cnt <= '0;
        r_win        <= '0;
      end else if (r_scroll_cnt == SCR_LAST) begin
        r_scroll_cnt <= '0;
        r_win        <= (r_win == WIN_LAST) ? '0 : r_win + 1'b1;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  // Active-low segments, gfedcba order; bits above TAP_W pad as zero.
  always_comb begin
    w_pad = '0;
    w_pad[TAP_W-1:0] = r_disp;
    w_win_val = '0;
    for (int w = 0; w < WINDOWS; w++)
      if (r_win == WIN_W'(w)) w_win_val = w_pad[w*WIN_BITS +: WIN_BITS];
    HexValue = '0;
    for (int d = 0; d < NUM_DIGITS; d++) HexValue[d*7 +: 7] = hex7(w_win_val[d*4 +: 4]);
    HexCycle = '0;
    for (int d = 0; d < CYC_W/4; d++) HexCycle[d*7 +: 7] = hex7(r_cycles[d*4 +: 4]);
  end

  assign StepPulse  = r_step_pulse;
  assign CycleCount = r_cycles;
  assign WinIdx     = r_win;
  assign Halted     = w_halted;

endmodule
